// File: rtl/mips_pkg.sv
// Shared types and widths for the MIPS pipeline stages.
package mips_pkg;

  localparam int unsigned WB_CTRL_W  = 2;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned WORD_W     = 32;

  typedef enum logic [0:0] {
    MEM_IDLE,
    MEM_BUSY
  } mem_state_e;

endpackage

// File: rtl/data_mem.sv
// Single-port word-addressed data RAM with a registered, write-first read port.
module data_mem
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata
);

  logic [WORD_W-1:0] mem [0:(1 << DEPTH_LOG2)-1];

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[idx] <= wdata;
    end
  end

  // Read register holds when disabled so it can serve as MEM/WB load data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (en) begin
      rdata <= we ? wdata : mem[idx];
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage: multi-cycle data RAM access with upstream stall and MEM/WB register.
module mem_stage
  import mips_pkg::*;
#(
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WB_CTRL_W-1:0]  wb_ctrl_in,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [WORD_W-1:0]     addr,
  input  logic [WORD_W-1:0]     store_data,
  input  logic [REG_ADDR_W-1:0] dest_in,
  output logic                  stall,
  output logic [WB_CTRL_W-1:0]  wb_ctrl_out,
  output logic [WORD_W-1:0]     read_data_out,
  output logic [WORD_W-1:0]     alu_out,
  output logic [REG_ADDR_W-1:0] dest_out,
  output logic                  misalign_out
);

  localparam bit          HasLat  = (LATENCY > 0);
  localparam int unsigned CntW    = HasLat ? $clog2(LATENCY + 1) : 1;
  localparam int unsigned CntInit = HasLat ? LATENCY - 1 : 0;

  mem_state_e            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  access, req, bad;
  logic                  mem_we;
  logic [WB_CTRL_W-1:0]  wb_ctrl_q;
  logic [WORD_W-1:0]     alu_q;
  logic [REG_ADDR_W-1:0] dest_q;
  logic                  misalign_q;

  assign access = mem_read | mem_write;
  assign req    = access & (addr[1:0] == 2'b00);
  assign bad    = access & (addr[1:0] != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MEM_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      MEM_IDLE: begin
        if (req && HasLat) begin
          cnt_d   = CntW'(CntInit);
          state_d = MEM_BUSY;
        end
      end
      MEM_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          state_d = MEM_IDLE;
        end
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  // Completion happens on any cycle that is not stalled; the write is gated by it too.
  always_comb begin
    stall  = HasLat & req & ~((state_q == MEM_BUSY) && (cnt_q == '0));
    mem_we = mem_write & ~bad;
  end

  data_mem #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_data_mem (
    .clk  (clk),
    .rst  (rst),
    .en   (~stall),
    .we   (mem_we),
    .idx  (addr[DEPTH_LOG2+1:2]),
    .wdata(store_data),
    .rdata(read_data_out)
  );

  // Stalled cycles push a bubble into write-back; data fields hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_ctrl_q  <= '0;
      alu_q      <= '0;
      dest_q     <= '0;
      misalign_q <= 1'b0;
    end else if (stall) begin
      wb_ctrl_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      wb_ctrl_q  <= bad ? '0 : wb_ctrl_in;
      alu_q      <= addr;
      dest_q     <= dest_in;
      misalign_q <= bad;
    end
  end

  assign wb_ctrl_out  = wb_ctrl_q;
  assign alu_out      = alu_q;
  assign dest_out     = dest_q;
  assign misalign_out = misalign_q;

endmodule
